// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer, instruction memory and IF/ID.
// master: the sequencer (drives imem_addr, if_* and busy).
// slave : the environment (drives control, redirect and memory read data).
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               enable;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_valid;
  logic               busy;

  modport master (
    input  enable, stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_instr, if_pc, if_valid, busy
  );

  modport slave (
    output enable, stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_instr, if_pc, if_valid, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses imem, presents instr+PC to IF/ID.
// Latency: capture on the (WAIT_CYCLES+1)-th edge in WAIT; one instruction per WAIT_CYCLES+2 cycles.
// Backpressure: stall holds the presented instruction; redirect flushes it and overrides stall.
// Ports: clk/reset (async, active-high); bus (master modport) carries enable, stall,
//        redirect/redirect_pc, imem_addr/imem_instr, if_instr/if_pc/if_valid and busy.
module fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 8,
  parameter int PC_STEP     = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int RESET_PC    = 0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [2:0]        WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    if (bus.redirect) begin
      // Redirect beats stall, enable and the settle count; a capture due on
      // this edge is dropped because valid_d is forced low.
      pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
      cnt_d   = WAIT_INIT;
      state_d = bus.enable ? WAIT : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
        WAIT: begin
          // enable is deliberately ignored here: a started fetch always completes.
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            instr_d = bus.imem_instr;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + STEP;  // wraps modulo 2^ADDR_W
            state_d = VALID;
          end
        end
        VALID: begin
          if (!bus.stall) begin
            valid_d = 1'b0;
            if (bus.enable) begin
              state_d = WAIT;
              cnt_d   = WAIT_INIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // imem_addr is the PC register itself, so the two can never disagree.
  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;
  assign bus.if_valid  = valid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instance A (W=1, RESET_PC=0) covers reset,
// stall, redirect and enable drop; instance B (W=0, RESET_PC=248) covers PC wrap.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) ifa ();
  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) ifb ();

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .PC_STEP(4), .WAIT_CYCLES(1), .RESET_PC(0))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .PC_STEP(4), .WAIT_CYCLES(0), .RESET_PC(248))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  // Instruction memory contents: word index w holds w*7+3 (mod 256).
  function automatic logic [7:0] memf(input logic [7:0] a);
    logic [7:0] w;
    w = a >> 2;
    return 8'(w * 8'd7 + 8'd3);
  endfunction

  assign ifa.imem_instr = memf(ifa.imem_addr);
  assign ifb.imem_instr = memf(ifb.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_valid(input string tag, input logic [7:0] pc, input logic [7:0] addr);
    chk({tag, "_valid"}, 32'(ifa.if_valid), 32'd1);
    chk({tag, "_pc"}, 32'(ifa.if_pc), 32'(pc));
    chk({tag, "_instr"}, 32'(ifa.if_instr), 32'(memf(pc)));
    chk({tag, "_addr"}, 32'(ifa.imem_addr), 32'(addr));
  endtask

  initial begin
    logic [7:0] pcs [4];
    pcs[0] = 8'hF8; pcs[1] = 8'hFC; pcs[2] = 8'h00; pcs[3] = 8'h04;

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.enable = 1'b0; ifa.stall = 1'b0; ifa.redirect = 1'b0; ifa.redirect_pc = '0;
    ifb.enable = 1'b0; ifb.stall = 1'b0; ifb.redirect = 1'b0; ifb.redirect_pc = '0;
    #2;
    chk("rst_addr", 32'(ifa.imem_addr), 32'd0);
    chk("rst_valid", 32'(ifa.if_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_pc", 32'(ifa.if_pc), 32'd0);
    chk("rst_instr", 32'(ifa.if_instr), 32'd0);
    chk("rstb_addr", 32'(ifb.imem_addr), 32'hF8);

    // Enter WAIT, then hit reset asynchronously mid-WAIT.
    tick();
    rst_a = 1'b0; ifa.enable = 1'b1;
    tick();
    chk("wait_busy", 32'(ifa.busy), 32'd1);
    chk("wait_valid", 32'(ifa.if_valid), 32'd0);
    rst_a = 1'b1;
    #1;
    chk("arst_busy", 32'(ifa.busy), 32'd0);
    chk("arst_valid", 32'(ifa.if_valid), 32'd0);
    chk("arst_addr", 32'(ifa.imem_addr), 32'd0);
    rst_a = 1'b0;

    // W=1: capture on the 3rd edge after release.
    tick(); chk("lat_e1", 32'(ifa.if_valid), 32'd0);
    tick(); chk("lat_e2", 32'(ifa.if_valid), 32'd0);
    tick(); chk_a_valid("first", 8'h00, 8'h04);
    tick(); chk("gap1", 32'(ifa.if_valid), 32'd0);
    tick(); chk("gap2", 32'(ifa.if_valid), 32'd0);
    tick(); chk_a_valid("second", 8'h04, 8'h08);
    tick(); tick(); tick();
    chk_a_valid("third", 8'h08, 8'h0C);

    // Stall holds the presented instruction for 5 cycles.
    ifa.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a_valid("stall", 8'h08, 8'h0C);
    end
    ifa.stall = 1'b0;
    tick(); chk("unstall_valid", 32'(ifa.if_valid), 32'd0);
    tick();
    tick(); chk_a_valid("after_stall", 8'h0C, 8'h10);

    // Redirect while VALID and stalled: flush and realign.
    ifa.stall = 1'b1; ifa.redirect = 1'b1; ifa.redirect_pc = 8'h23;
    tick();
    chk("redir_valid", 32'(ifa.if_valid), 32'd0);
    chk("redir_addr", 32'(ifa.imem_addr), 32'h20);
    chk("redir_busy", 32'(ifa.busy), 32'd1);
    ifa.redirect = 1'b0; ifa.stall = 1'b0;
    tick();
    tick(); chk_a_valid("redir_tgt", 8'h20, 8'h24);

    // Redirect on the capture edge discards the pending capture.
    tick(); chk("cap_consume", 32'(ifa.if_valid), 32'd0);
    tick();
    ifa.redirect = 1'b1; ifa.redirect_pc = 8'h40;
    tick();
    chk("capredir_valid", 32'(ifa.if_valid), 32'd0);
    chk("capredir_addr", 32'(ifa.imem_addr), 32'h40);
    ifa.redirect = 1'b0;
    tick(); chk("capredir_gap", 32'(ifa.if_valid), 32'd0);
    tick(); chk_a_valid("capredir_tgt", 8'h40, 8'h44);

    // Drop enable during WAIT: fetch still completes, then park in IDLE.
    tick();
    ifa.enable = 1'b0;
    tick();
    tick(); chk_a_valid("noen_fetch", 8'h44, 8'h48);
    chk("noen_busy1", 32'(ifa.busy), 32'd1);
    tick();
    chk("idle_valid", 32'(ifa.if_valid), 32'd0);
    chk("idle_busy", 32'(ifa.busy), 32'd0);
    repeat (3) tick();
    chk("idle_addr", 32'(ifa.imem_addr), 32'h48);
    chk("idle_busy2", 32'(ifa.busy), 32'd0);

    // Instance B: W=0 from 248, delivery every 2 cycles across the wrap.
    rst_b = 1'b0; ifb.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_gap", 32'(ifb.if_valid), 32'd0);
      tick();
      chk("wrap_valid", 32'(ifb.if_valid), 32'd1);
      chk("wrap_pc", 32'(ifb.if_pc), 32'(pcs[k]));
      chk("wrap_instr", 32'(ifb.if_instr), 32'(memf(pcs[k])));
      chk("wrap_addr", 32'(ifb.imem_addr), 32'(8'(pcs[k] + 8'd4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
